// File: rtl/window_pkg.sv
// Shared types and constants for the register-window control unit.
`default_nettype none

package window_pkg;

  localparam int NWIN_DEF = 4;
  localparam int CWPW_DEF = 2;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EVAL = 2'b01,
    TRAP = 2'b10
  } state_t;

  // Pending window operation carried from IDLE into EVAL.
  typedef enum logic [1:0] {
    OP_SAVE      = 2'b00,
    OP_RESTORE   = 2'b01,
    OP_TRAPENTRY = 2'b10,
    OP_RETT      = 2'b11
  } op_t;

  localparam logic [1:0] TT_NONE = 2'b00;
  localparam logic [1:0] TT_OVF  = 2'b01;
  localparam logic [1:0] TT_UNF  = 2'b10;
  localparam logic [1:0] TT_ILL  = 2'b11;

endpackage

`default_nettype wire

// File: rtl/cwp_next.sv
// Modular step of a window pointer: dir=1 increments, dir=0 decrements, wrapping at NWIN.
`default_nettype none

module cwp_next #(
  parameter int NWIN = 4,
  parameter int CWPW = 2
) (
  input  logic [CWPW-1:0] cwp,
  input  logic            dir,
  output logic [CWPW-1:0] target
);

  localparam logic [CWPW-1:0] LAST = CWPW'(NWIN - 1);

  always_comb begin
    target = cwp;
    if (dir) begin
      target = (cwp == LAST) ? '0 : cwp + 1'b1;
    end else begin
      target = (cwp == '0) ? LAST : cwp - 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/window_control_unit.sv
// Owns CWP and WIM, sequences SAVE/RESTORE/trap-entry/RETT window moves and raises window traps.
`default_nettype none

module window_control_unit
  import window_pkg::*;
#(
  parameter int NWIN = NWIN_DEF,
  parameter int CWPW = CWPW_DEF
) (
  input  logic            Clk,
  input  logic            Clr,
  input  logic            Save,
  input  logic            Restore,
  input  logic            TrapEntry,
  input  logic            Rett,
  input  logic            CwpWE,
  input  logic [CWPW-1:0] CwpIn,
  input  logic            WimWE,
  input  logic [NWIN-1:0] WimIn,
  input  logic            TrapAck,
  output logic [CWPW-1:0] CWP,
  output logic [NWIN-1:0] WIM,
  output logic            Ready,
  output logic            Done,
  output logic            Trap,
  output logic [1:0]      TrapType
);

  localparam logic [NWIN-1:0] WIM_RST  = NWIN'(2);
  localparam logic [CWPW:0]   NWIN_EXT = (CWPW + 1)'(NWIN);

  state_t          state_q;
  op_t             op_q;
  logic [CWPW-1:0] cwp_q;
  logic [CWPW-1:0] target_q;
  logic [NWIN-1:0] wim_q;
  logic            done_q;
  logic [1:0]      ttype_q;

  logic [4:0]      req_vec;
  logic            multi_req;
  logic            any_step;
  logic            step_dir;
  logic            cwp_legal;
  logic [CWPW-1:0] step_target;

  always_comb begin
    req_vec   = {Save, Restore, TrapEntry, Rett, CwpWE};
    multi_req = ($countones(req_vec) > 1);
    any_step  = Save | Restore | TrapEntry | Rett;
    step_dir  = Restore | Rett;
    cwp_legal = ({1'b0, CwpIn} < NWIN_EXT);
  end

  cwp_next #(
    .NWIN (NWIN),
    .CWPW (CWPW)
  ) u_cwp_next (
    .cwp    (cwp_q),
    .dir    (step_dir),
    .target (step_target)
  );

  always_ff @(posedge Clk) begin
    if (!Clr) begin
      state_q  <= IDLE;
      op_q     <= OP_SAVE;
      cwp_q    <= '0;
      target_q <= '0;
      wim_q    <= WIM_RST;
      done_q   <= 1'b0;
      ttype_q  <= TT_NONE;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // WIM write lands even alongside an illegal request, and EVAL sees the new mask.
          if (WimWE) wim_q <= WimIn;
          if (multi_req) begin
            state_q <= TRAP;
            ttype_q <= TT_ILL;
          end else if (CwpWE) begin
            if (cwp_legal) begin
              cwp_q  <= CwpIn;
              done_q <= 1'b1;
            end else begin
              state_q <= TRAP;
              ttype_q <= TT_ILL;
            end
          end else if (any_step) begin
            target_q <= step_target;
            op_q     <= Save      ? OP_SAVE      :
                        Restore   ? OP_RESTORE   :
                        TrapEntry ? OP_TRAPENTRY : OP_RETT;
            state_q  <= EVAL;
          end
        end
        EVAL: begin
          if ((op_q != OP_TRAPENTRY) && wim_q[target_q]) begin
            state_q <= TRAP;
            ttype_q <= (op_q == OP_SAVE) ? TT_OVF : TT_UNF;
          end else begin
            cwp_q   <= target_q;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        TRAP: begin
          if (TrapAck) begin
            state_q <= IDLE;
            ttype_q <= TT_NONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign CWP      = cwp_q;
  assign WIM      = wim_q;
  assign Ready    = (state_q == IDLE);
  assign Trap     = (state_q == TRAP);
  assign Done     = done_q;
  assign TrapType = ttype_q;

endmodule

`default_nettype wire

// File: tb/tb_window_control_unit.sv
// Directed vector bench for window_control_unit (NWIN=4).
`default_nettype none

module tb_window_control_unit;

  logic       Clk = 1'b0;
  logic       Clr;
  logic       Save, Restore, TrapEntry, Rett, CwpWE, WimWE, TrapAck;
  logic [1:0] CwpIn;
  logic [3:0] WimIn;
  logic [1:0] CWP;
  logic [3:0] WIM;
  logic       Ready, Done, Trap;
  logic [1:0] TrapType;

  int errors = 0;
  int checks = 0;

  window_control_unit dut (
    .Clk      (Clk),
    .Clr      (Clr),
    .Save     (Save),
    .Restore  (Restore),
    .TrapEntry(TrapEntry),
    .Rett     (Rett),
    .CwpWE    (CwpWE),
    .CwpIn    (CwpIn),
    .WimWE    (WimWE),
    .WimIn    (WimIn),
    .TrapAck  (TrapAck),
    .CWP      (CWP),
    .WIM      (WIM),
    .Ready    (Ready),
    .Done     (Done),
    .Trap     (Trap),
    .TrapType (TrapType)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic       clr;
    logic [4:0] req;   // {Save, Restore, TrapEntry, Rett, CwpWE}
    logic [1:0] cwpin;
    logic       wimwe;
    logic [3:0] wimin;
    logic       ack;
    logic [1:0] cwp;
    logic [3:0] wim;
    logic       ready;
    logic       done;
    logic       trap;
    logic [1:0] tt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic clr, input logic [4:0] req, input logic [1:0] cwpin,
                              input logic wimwe, input logic [3:0] wimin, input logic ack,
                              input logic [1:0] cwp, input logic [3:0] wim, input logic ready,
                              input logic done, input logic trap, input logic [1:0] tt);
    vec_t v;
    v.clr = clr; v.req = req; v.cwpin = cwpin; v.wimwe = wimwe; v.wimin = wimin; v.ack = ack;
    v.cwp = cwp; v.wim = wim; v.ready = ready; v.done = done; v.trap = trap; v.tt = tt;
    return v;
  endfunction

  task automatic drive(input logic clr, input logic [4:0] req, input logic [1:0] cwpin,
                       input logic wimwe, input logic [3:0] wimin, input logic ack);
    Clr = clr;
    {Save, Restore, TrapEntry, Rett, CwpWE} = req;
    CwpIn = cwpin; WimWE = wimwe; WimIn = wimin; TrapAck = ack;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string name, input logic [1:0] cwp, input logic [3:0] wim,
                       input logic ready, input logic done, input logic trap, input logic [1:0] tt);
    logic [10:0] got, exp;
    got = {CWP, WIM, Ready, Done, Trap, TrapType};
    exp = {cwp, wim, ready, done, trap, tt};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got CWP=%0d WIM=%b Ready=%b Done=%b Trap=%b TT=%b, expected CWP=%0d WIM=%b Ready=%b Done=%b Trap=%b TT=%b",
               name, CWP, WIM, Ready, Done, Trap, TrapType, cwp, wim, ready, done, trap, tt);
    end
  endtask

  initial begin
    drive(1'b0, 5'b0, 2'd0, 1'b0, 4'b0, 1'b0);

    // clr  req      cwpin wimwe wimin    ack   cwp  wim      rdy   done  trap  tt
    vecs.push_back(mk(0, 5'b00000, 2'd0, 0, 4'b0000, 0,  2'd0, 4'b0010, 1, 0, 0, 2'd0)); // reset
    vecs.push_back(mk(1, 5'b10000, 2'd0, 0, 4'b0000, 0,  2'd0, 4'b0010, 0, 0, 0, 2'd0)); // Save -> EVAL
    vecs.push_back(mk(1, 5'b00000, 2'd0, 0, 4'b0000, 0,  2'd3, 4'b0010, 1, 1, 0, 2'd0)); // wrap 0-1=3
    vecs.push_back(mk(1, 5'b00000, 2'd0, 0, 4'b0000, 0,  2'd3, 4'b0010, 1, 0, 0, 2'd0));
    vecs.push_back(mk(0, 5'b00000, 2'd0, 0, 4'b0000, 0,  2'd0, 4'b0010, 1, 0, 0, 2'd0)); // reset
    vecs.push_back(mk(1, 5'b01000, 2'd0, 0, 4'b0000, 0,  2'd0, 4'b0010, 0, 0, 0, 2'd0)); // Restore
    vecs.push_back(mk(1, 5'b00000, 2'd0, 0, 4'b0000, 0,  2'd0, 4'b0010, 0, 0, 1, 2'd2)); // underflow
    vecs.push_back(mk(1, 5'b00000, 2'd0, 0, 4'b0000, 0,  2'd0, 4'b0010, 0, 0, 1, 2'd2));
    vecs.push_back(mk(1, 5'b00000, 2'd0, 0, 4'b0000, 1,  2'd0, 4'b0010, 1, 0, 0, 2'd0)); // ack
    vecs.push_back(mk(1, 5'b00000, 2'd0, 1, 4'b1000, 0,  2'd0, 4'b1000, 1, 0, 0, 2'd0)); // WRWIM
    vecs.push_back(mk(1, 5'b10000, 2'd0, 0, 4'b0000, 0,  2'd0, 4'b1000, 0, 0, 0, 2'd0)); // Save
    vecs.push_back(mk(1, 5'b00000, 2'd0, 0, 4'b0000, 0,  2'd0, 4'b1000, 0, 0, 1, 2'd1)); // overflow
    vecs.push_back(mk(1, 5'b00000, 2'd0, 0, 4'b0000, 1,  2'd0, 4'b1000, 1, 0, 0, 2'd0));
    vecs.push_back(mk(1, 5'b00100, 2'd0, 0, 4'b0000, 0,  2'd0, 4'b1000, 0, 0, 0, 2'd0)); // TrapEntry
    vecs.push_back(mk(1, 5'b00000, 2'd0, 0, 4'b0000, 0,  2'd3, 4'b1000, 1, 1, 0, 2'd0)); // no WIM check
    vecs.push_back(mk(1, 5'b00000, 2'd0, 1, 4'b0000, 0,  2'd3, 4'b0000, 1, 0, 0, 2'd0));
    vecs.push_back(mk(1, 5'b00001, 2'd1, 0, 4'b0000, 0,  2'd1, 4'b0000, 1, 1, 0, 2'd0)); // WRPSR
    vecs.push_back(mk(1, 5'b00001, 2'd3, 0, 4'b0000, 0,  2'd3, 4'b0000, 1, 1, 0, 2'd0));
    vecs.push_back(mk(1, 5'b01000, 2'd0, 0, 4'b0000, 0,  2'd3, 4'b0000, 0, 0, 0, 2'd0)); // Restore
    vecs.push_back(mk(1, 5'b00000, 2'd0, 0, 4'b0000, 0,  2'd0, 4'b0000, 1, 1, 0, 2'd0)); // wrap 3+1=0
    vecs.push_back(mk(1, 5'b00010, 2'd0, 0, 4'b0000, 0,  2'd0, 4'b0000, 0, 0, 0, 2'd0)); // Rett
    vecs.push_back(mk(1, 5'b00000, 2'd0, 0, 4'b0000, 0,  2'd1, 4'b0000, 1, 1, 0, 2'd0));
    vecs.push_back(mk(1, 5'b11000, 2'd0, 0, 4'b0000, 0,  2'd1, 4'b0000, 0, 0, 1, 2'd3)); // conflict
    vecs.push_back(mk(1, 5'b00000, 2'd0, 0, 4'b0000, 1,  2'd1, 4'b0000, 1, 0, 0, 2'd0));
    vecs.push_back(mk(1, 5'b00001, 2'd0, 0, 4'b0000, 0,  2'd0, 4'b0000, 1, 1, 0, 2'd0));
    vecs.push_back(mk(1, 5'b10000, 2'd0, 1, 4'b1000, 0,  2'd0, 4'b1000, 0, 0, 0, 2'd0)); // Save+WRWIM
    vecs.push_back(mk(1, 5'b00000, 2'd0, 0, 4'b0000, 0,  2'd0, 4'b1000, 0, 0, 1, 2'd1)); // new WIM used
    vecs.push_back(mk(1, 5'b10000, 2'd0, 1, 4'b0000, 0,  2'd0, 4'b1000, 0, 0, 1, 2'd1)); // ignored in TRAP
    vecs.push_back(mk(1, 5'b00000, 2'd0, 0, 4'b0000, 1,  2'd0, 4'b1000, 1, 0, 0, 2'd0));
    vecs.push_back(mk(1, 5'b10010, 2'd0, 1, 4'b0000, 0,  2'd0, 4'b0000, 0, 0, 1, 2'd3)); // conflict+WRWIM
    vecs.push_back(mk(1, 5'b00000, 2'd0, 0, 4'b0000, 1,  2'd0, 4'b0000, 1, 0, 0, 2'd0));
    vecs.push_back(mk(1, 5'b00000, 2'd0, 0, 4'b0000, 1,  2'd0, 4'b0000, 1, 0, 0, 2'd0)); // ack in IDLE
    vecs.push_back(mk(1, 5'b10000, 2'd0, 0, 4'b0000, 0,  2'd0, 4'b0000, 0, 0, 0, 2'd0)); // Save
    vecs.push_back(mk(1, 5'b01000, 2'd0, 1, 4'b1111, 0,  2'd3, 4'b0000, 1, 1, 0, 2'd0)); // ignored in EVAL
    vecs.push_back(mk(1, 5'b00000, 2'd0, 0, 4'b0000, 0,  2'd3, 4'b0000, 1, 0, 0, 2'd0));
    vecs.push_back(mk(1, 5'b10001, 2'd2, 0, 4'b0000, 0,  2'd3, 4'b0000, 0, 0, 1, 2'd3)); // CwpWE+Save
    vecs.push_back(mk(1, 5'b00000, 2'd0, 0, 4'b0000, 1,  2'd3, 4'b0000, 1, 0, 0, 2'd0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].clr, vecs[i].req, vecs[i].cwpin, vecs[i].wimwe, vecs[i].wimin, vecs[i].ack);
      tick();
      check($sformatf("vec%0d", i), vecs[i].cwp, vecs[i].wim, vecs[i].ready,
            vecs[i].done, vecs[i].trap, vecs[i].tt);
    end

    // Reset while in EVAL: the pending SAVE must not commit or pulse Done.
    drive(1'b1, 5'b10000, 2'd0, 1'b0, 4'b0, 1'b0);
    tick();
    check("eval_entered", 2'd3, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0);
    drive(1'b0, 5'b00000, 2'd0, 1'b0, 4'b0, 1'b0);
    tick();
    check("clr_in_eval", 2'd0, 4'b0010, 1'b1, 1'b0, 1'b0, 2'd0);
    drive(1'b1, 5'b00000, 2'd0, 1'b0, 4'b0, 1'b0);
    tick();
    check("after_clr_eval", 2'd0, 4'b0010, 1'b1, 1'b0, 1'b0, 2'd0);

    // Underflow trap held for several cycles without ack, then reset while in TRAP.
    drive(1'b1, 5'b01000, 2'd0, 1'b0, 4'b0, 1'b0);
    tick();
    drive(1'b1, 5'b00000, 2'd0, 1'b0, 4'b0, 1'b0);
    tick();
    for (int i = 0; i < 5; i++) begin
      if (i == 2) drive(1'b1, 5'b00001, 2'd2, 1'b1, 4'b0000, 1'b0);
      else        drive(1'b1, 5'b00000, 2'd0, 1'b0, 4'b0, 1'b0);
      check($sformatf("trap_hold%0d", i), 2'd0, 4'b0010, 1'b0, 1'b0, 1'b1, 2'd2);
      tick();
    end
    check("trap_hold_end", 2'd0, 4'b0010, 1'b0, 1'b0, 1'b1, 2'd2);
    drive(1'b0, 5'b00000, 2'd0, 1'b0, 4'b0, 1'b0);
    tick();
    check("clr_in_trap", 2'd0, 4'b0010, 1'b1, 1'b0, 1'b0, 2'd0);
    drive(1'b1, 5'b00000, 2'd0, 1'b0, 4'b0, 1'b0);
    tick();
    check("after_clr_trap", 2'd0, 4'b0010, 1'b1, 1'b0, 1'b0, 2'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
